// File: rtl/nanov_store_uart_tx_if.sv
// rtl/nanov_store_uart_tx_if.sv - store port bundle from the core into the UART sink
interface nanov_store_uart_tx_if;
   logic [31:0] data_in;
   logic        store_in;

   modport master (output data_in, output store_in);
   modport slave  (input  data_in, input  store_in);
endinterface

// File: rtl/nanov_store_uart_tx.sv
// rtl/nanov_store_uart_tx.sv - store-word FIFO serialised as UART bytes, low byte first
// Define NANOV_STORE_UART_PARITY_EN for 8E1 framing (even parity bit ahead of the stop bit).
module nanov_store_uart_tx #(
   parameter int DEPTH      = 4,
   parameter int CLK_DIV    = 104,
   parameter int SEND_BYTES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   nanov_store_uart_tx_if.slave   st,
   output logic                   uart_tx,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic                   fifo_full,
   output logic                   overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int BW = $clog2(CLK_DIV);

   localparam logic [BW-1:0] BAUD_LAST  = BW'(CLK_DIV - 1);
   localparam logic [BW-1:0] BAUD_ONE   = BW'(1);
   localparam logic [AW-1:0] PTR_ONE    = AW'(1);
   localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
   localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
   localparam logic [1:0]    LAST_BYTE  = 2'(SEND_BYTES - 1);

`ifdef NANOV_STORE_UART_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_PARITY} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   state_t        state;
   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [31:0]   shreg;
   logic [7:0]    cur_byte;
   logic [BW-1:0] baud;
   logic [2:0]    bit_idx;
   logic [1:0]    byte_idx;
   logic          baud_done;
   logic          word_done;
   logic          pop;
   logic          push;

   assign cur_byte  = shreg[7:0];
   assign fifo_full = (fifo_count == FULL_COUNT);
   assign busy      = (state != S_IDLE) || (fifo_count != '0);

   // A full FIFO still accepts a store on the edge that frees the head slot.
   always_comb begin
      baud_done = (baud == '0);
      word_done = (state == S_STOP) && baud_done && (byte_idx == LAST_BYTE);
      pop       = (fifo_count != '0) && ((state == S_IDLE) || word_done);
      push      = st.store_in && (!fifo_full || pop);
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= st.data_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         if (push && !pop) begin
            fifo_count <= fifo_count + CNT_ONE;
         end else if (pop && !push) begin
            fifo_count <= fifo_count - CNT_ONE;
         end
         if (st.store_in && !push) begin
            overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         uart_tx  <= 1'b1;
         shreg    <= '0;
         baud     <= '0;
         bit_idx  <= '0;
         byte_idx <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               uart_tx <= 1'b1;
               if (pop) begin
                  shreg    <= mem[rd_ptr];
                  byte_idx <= '0;
                  baud     <= BAUD_LAST;
                  uart_tx  <= 1'b0;
                  state    <= S_START;
               end
            end
            S_START: begin
               if (baud_done) begin
                  baud    <= BAUD_LAST;
                  bit_idx <= '0;
                  uart_tx <= cur_byte[0];
                  state   <= S_DATA;
               end else begin
                  baud <= baud - BAUD_ONE;
               end
            end
            S_DATA: begin
               if (baud_done) begin
                  baud <= BAUD_LAST;
                  if (bit_idx == 3'd7) begin
`ifdef NANOV_STORE_UART_PARITY_EN
                     uart_tx <= ^cur_byte;
                     state   <= S_PARITY;
`else
                     uart_tx <= 1'b1;
                     state   <= S_STOP;
`endif
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     uart_tx <= cur_byte[bit_idx + 3'd1];
                  end
               end else begin
                  baud <= baud - BAUD_ONE;
               end
            end
`ifdef NANOV_STORE_UART_PARITY_EN
            S_PARITY: begin
               if (baud_done) begin
                  baud    <= BAUD_LAST;
                  uart_tx <= 1'b1;
                  state   <= S_STOP;
               end else begin
                  baud <= baud - BAUD_ONE;
               end
            end
`endif
            S_STOP: begin
               if (baud_done) begin
                  // Next byte of the same word, else the next queued word, with no idle gap.
                  if (byte_idx != LAST_BYTE) begin
                     shreg    <= shreg >> 8;
                     byte_idx <= byte_idx + 2'd1;
                     baud     <= BAUD_LAST;
                     uart_tx  <= 1'b0;
                     state    <= S_START;
                  end else if (pop) begin
                     shreg    <= mem[rd_ptr];
                     byte_idx <= '0;
                     baud     <= BAUD_LAST;
                     uart_tx  <= 1'b0;
                     state    <= S_START;
                  end else begin
                     uart_tx <= 1'b1;
                     state   <= S_IDLE;
                  end
               end else begin
                  baud <= baud - BAUD_ONE;
               end
            end
            default: begin
               uart_tx <= 1'b1;
               state   <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_nanov_store_uart_tx.sv
// tb/tb_nanov_store_uart_tx.sv - directed checks of the store-port UART sink
module tb_nanov_store_uart_tx;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   nanov_store_uart_tx_if if1 ();
   nanov_store_uart_tx_if if4 ();

   logic       tx1, busy1, full1, ovf1;
   logic       tx4, busy4, full4, ovf4;
   logic [2:0] cnt1, cnt4;

   nanov_store_uart_tx #(.DEPTH(4), .CLK_DIV(4), .SEND_BYTES(1)) u1 (
      .clk(clk), .rst(rst), .st(if1), .uart_tx(tx1), .busy(busy1),
      .fifo_count(cnt1), .fifo_full(full1), .overflow(ovf1));

   nanov_store_uart_tx #(.DEPTH(4), .CLK_DIV(4), .SEND_BYTES(4)) u4 (
      .clk(clk), .rst(rst), .st(if4), .uart_tx(tx4), .busy(busy4),
      .fifo_count(cnt4), .fifo_full(full4), .overflow(ovf4));

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] w3 [5] = '{32'h0000_0011, 32'h0000_0022, 32'h0000_0033, 32'h0000_0044, 32'h0000_005A};
   logic [31:0] w4 [6] = '{32'h0000_0081, 32'h0000_0042, 32'h0000_00C3, 32'h0000_0024,
                           32'h0000_00A5, 32'h0000_0066};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic txv(input bit which);
      return which ? tx4 : tx1;
   endfunction

   task automatic wait_start(input bit which, input string tag);
      int n = 0;
      while (txv(which) !== 1'b0 && n < 200) begin
         tick();
         n++;
      end
      check(tag, 32'(txv(which)), 32'd0);
   endtask

   // Entered on the sample right after the start-bit edge; returns at the next frame's start edge.
   task automatic decode(input bit which, input logic [7:0] exp, input string tag);
      logic [7:0] b;
      check({tag, " start"}, 32'(txv(which)), 32'd0);
      tick(2);
      for (int i = 0; i < 8; i++) begin
         tick(4);
         b[i] = txv(which);
      end
      check({tag, " data"}, 32'(b), 32'(exp));
`ifdef NANOV_STORE_UART_PARITY_EN
      tick(4);
      check({tag, " parity"}, 32'(txv(which)), 32'(^exp));
`endif
      tick(4);
      check({tag, " stop"}, 32'(txv(which)), 32'd1);
      tick(2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got still running, expected finished");
      $fatal(1, "time limit");
   end

   initial begin
      rst = 1'b1;
      if1.store_in = 1'b0; if1.data_in = '0;
      if4.store_in = 1'b0; if4.data_in = '0;
      tick(2);
      rst = 1'b0;
      tick();

      check("reset tx",       32'(tx1),   32'd1);
      check("reset busy",     32'(busy1), 32'd0);
      check("reset count",    32'(cnt1),  32'd0);
      check("reset overflow", 32'(ovf1),  32'd0);
      check("reset full",     32'(full1), 32'd0);
      check("reset tx4",      32'(tx4),   32'd1);

      // single byte 0x55, 1-cycle latency, busy low on cycle 41
      if1.data_in = 32'h0000_0055; if1.store_in = 1'b1;
      tick();
      if1.store_in = 1'b0;
      check("t1 count", 32'(cnt1),  32'd1);
      check("t1 busy",  32'(busy1), 32'd1);
      check("t1 idle",  32'(tx1),   32'd1);
      tick();
      decode(0, 8'h55, "t1");
      check("t1 busy end", 32'(busy1), 32'd0);

      // four bytes per word, low byte first, back to back, 160 cycles
      if4.data_in = 32'hA1B2_C3D4; if4.store_in = 1'b1;
      tick();
      if4.store_in = 1'b0;
      tick();
      decode(1, 8'hD4, "t2 b0");
      decode(1, 8'hC3, "t2 b1");
      decode(1, 8'hB2, "t2 b2");
      decode(1, 8'hA1, "t2 b3");
      check("t2 busy end", 32'(busy4), 32'd0);

      // fill and overflow
      fork
         begin
            for (int i = 0; i < 5; i++) begin
               if1.data_in = w3[i]; if1.store_in = 1'b1;
               tick();
            end
            check("t3 count full", 32'(cnt1),  32'd4);
            check("t3 full",       32'(full1), 32'd1);
            check("t3 no ovf",     32'(ovf1),  32'd0);
            if1.data_in = 32'h0000_0066;
            tick();
            if1.store_in = 1'b0;
            check("t3 ovf",        32'(ovf1),  32'd1);
            check("t3 count held", 32'(cnt1),  32'd4);
         end
         begin
            wait_start(0, "t3 first start");
            for (int i = 0; i < 5; i++) decode(0, w3[i][7:0], "t3 word");
         end
      join
      check("t3 busy end",   32'(busy1), 32'd0);
      check("t3 count end",  32'(cnt1),  32'd0);
      check("t3 ovf sticky", 32'(ovf1),  32'd1);

      // push on the pop edge while full
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      check("t4 ovf cleared", 32'(ovf1), 32'd0);
      fork
         begin
            for (int i = 0; i < 5; i++) begin
               if1.data_in = w4[i]; if1.store_in = 1'b1;
               tick();
            end
            if1.store_in = 1'b0;
            check("t4 count full", 32'(cnt1), 32'd4);
            tick(36);
            if1.data_in = w4[5]; if1.store_in = 1'b1;
            tick();
            if1.store_in = 1'b0;
            check("t4 count same", 32'(cnt1), 32'd4);
            check("t4 no ovf",     32'(ovf1), 32'd0);
         end
         begin
            wait_start(0, "t4 first start");
            for (int i = 0; i < 6; i++) decode(0, w4[i][7:0], "t4 word");
         end
      join
      check("t4 busy end", 32'(busy1), 32'd0);

      // asynchronous reset during bit 2 of byte 1 (0xC3, bit 2 = 0)
      if4.data_in = 32'hA1B2_C3D4; if4.store_in = 1'b1;
      tick();
      if4.data_in = 32'h0BAD_F00D;
      tick();
      if4.store_in = 1'b0;
      tick(53);
      check("t5 mid bit",   32'(tx4),  32'd0);
      check("t5 mid count", 32'(cnt4), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("t5 async tx",    32'(tx4),   32'd1);
      check("t5 async count", 32'(cnt4),  32'd0);
      check("t5 async busy",  32'(busy4), 32'd0);
      tick(2);
      rst = 1'b0;
      tick();
      if4.data_in = 32'h1234_5678; if4.store_in = 1'b1;
      tick();
      if4.store_in = 1'b0;
      tick();
      decode(1, 8'h78, "t5 b0");
      decode(1, 8'h56, "t5 b1");
      decode(1, 8'h34, "t5 b2");
      decode(1, 8'h12, "t5 b3");
      check("t5 busy end", 32'(busy4), 32'd0);

`ifdef NANOV_STORE_UART_PARITY_EN
      if1.data_in = 32'h0000_0007; if1.store_in = 1'b1;
      tick();
      if1.store_in = 1'b0;
      tick();
      decode(0, 8'h07, "t6 p1");
      if1.data_in = 32'h0000_0003; if1.store_in = 1'b1;
      tick();
      if1.store_in = 1'b0;
      tick();
      decode(0, 8'h03, "t6 p0");
      check("t6 busy end", 32'(busy1), 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/nanov_store_uart_tx.md
Name: nanov_store_uart_tx

Overview:
- Downstream consumer of the CPU core's store port.
- Captures each 32-bit store word when the store strobe pulses and queues it in a small FIFO.
- Serialises each queued word as 8N1 UART bytes, least-significant byte first.
- Gives the SoC a debug/console output with no bus fabric: one store instruction produces one word on the wire.

Parameters:
- DEPTH, 4: FIFO depth in words. Power of two, 2..16.
- CLK_DIV, 104: clock cycles per UART bit, minimum 2.
- SEND_BYTES, 4: bytes transmitted per word, 1..4. Taken from data_in[7:0] upward.

Ports:
- clk  input  1  system clock, all logic on the rising edge
- rst  input  1  asynchronous, active-high reset
- data_in  input  32  store data from the core, valid while store_in=1
- store_in  input  1  single-cycle store strobe, one word per high cycle
- uart_tx  output  1  serial line, idle high
- busy  output  1  high while a frame is in flight or the FIFO is non-empty
- fifo_count  output  $clog2(DEPTH)+1  words queued, excluding the word being sent
- fifo_full  output  1  fifo_count==DEPTH
- overflow  output  1  sticky: a store was dropped because the FIFO was full

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - uart_tx=1, busy=0, fifo_count=0, fifo_full=0, overflow=0.
  - FIFO pointers cleared; FSM to IDLE; bit and baud counters cleared.
- Capture:
  - On a rising edge with store_in=1 and FIFO not full, data_in is written at wr_ptr and wr_ptr increments.
  - If the FIFO is full and no pop occurs that edge, the word is dropped and overflow is set. overflow is cleared only by rst.
- Pop:
  - Occurs on the edge where the FSM leaves IDLE or finishes the last byte of a word with the FIFO non-empty.
  - The head word loads into a 32-bit shift register and rd_ptr increments.
- Simultaneous push and pop:
  - Both take effect; fifo_count is unchanged.
  - A push when full is accepted if a pop happens on the same edge (no overflow).
- Pointer arithmetic:
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
  - fifo_count is tracked separately and distinguishes full from empty.
- FSM states: IDLE, START, DATA, STOP (plus PARITY when the optional feature is enabled).
  - IDLE: uart_tx=1. If fifo_count>0, pop, enter START, load baud counter with CLK_DIV-1, set byte index=0.
  - Latency: a store into an empty, idle block drives uart_tx low on the edge after the capturing edge (1 cycle).
  - START: uart_tx=0 for CLK_DIV cycles, then DATA with bit index=0.
  - DATA: uart_tx = current byte bit[index], LSB first, CLK_DIV cycles per bit. After bit 7, go to STOP.
  - STOP: uart_tx=1 for CLK_DIV cycles. Then:
    - byte index < SEND_BYTES-1: shift register right by 8, increment byte index, go to START (no idle gap between bytes).
    - otherwise, if the FIFO is non-empty: pop and go to START (back-to-back words).
    - otherwise: go to IDLE.
- Timing:
  - Baud counter counts down; bit boundaries occur at 0, where it reloads CLK_DIV-1.
  - Word duration = SEND_BYTES*10*CLK_DIV cycles (11 per byte with parity).
- busy = (state!=IDLE) || (fifo_count!=0).
- store_in held high for k cycles pushes k words (the core only pulses one cycle; this is not guarded).

Optional Feature:
- Macro: NANOV_STORE_UART_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP.
  - uart_tx = XOR of the 8 data bits (even parity) for CLK_DIV cycles.
  - Frame is 8E1, 11 bit-times per byte.
- Undefined:
  - No PARITY state; DATA goes directly to STOP.
  - 8N1, 10 bit-times per byte.
- The port list is identical either way.

Test Plan:
- Reset checks with CLK_DIV=4, SEND_BYTES=1:
  - After reset, uart_tx=1, busy=0, fifo_count=0, overflow=0.
  - Pulse store_in with data_in=32'h00000055. uart_tx falls 1 cycle later.
  - Line samples every 4 cycles read 0,1,0,1,0,1,0,1,0,1 (start, 0x55 LSB first, stop); busy drops on cycle 41.
- SEND_BYTES=4, CLK_DIV=4, store 32'hA1B2C3D4:
  - Bytes decoded in order D4, C3, B2, A1 with no idle between frames.
  - Total 160 cycles.
- Fill and overflow, DEPTH=4, CLK_DIV=4:
  - Five stores on consecutive cycles: first pops immediately, next four fill the FIFO (fifo_full=1).
  - A sixth store while full and not popping sets overflow=1, fifo_count stays 4.
  - The 5 accepted words are transmitted in order.
- Push with simultaneous pop:
  - With fifo_count=4, pulse store_in on the exact cycle the FSM pops.
  - Required: word accepted, fifo_count stays 4, overflow stays 0.
- Reset mid-frame:
  - Assert rst during the DATA state of byte 2.
  - uart_tx goes 1 immediately (asynchronously); fifo_count=0.
  - After release, the next store transmits cleanly from START.
- Parity, with NANOV_STORE_UART_PARITY_EN defined, SEND_BYTES=1:
  - Store 0x07: parity bit = 1, 11 bit-times.
  - Store 0x03: parity bit = 0.
